// File: rtl/pcie_rst_seq_pkg.sv
// pcie_rst_seq_pkg: sequencer state encoding shared by the reset sequencer and its bench.
package pcie_rst_seq_pkg;
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
   localparam logic [2:0] ST_PERST_HOLD = 3'd2;
   localparam logic [2:0] ST_USER_HOLD  = 3'd3;
   localparam logic [2:0] ST_LINK_WAIT  = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;
   localparam logic [2:0] ST_ERROR      = 3'd6;
   typedef enum logic [2:0] {
      IDLE       = ST_IDLE,
      WAIT_LOCK  = ST_WAIT_LOCK,
      PERST_HOLD = ST_PERST_HOLD,
      USER_HOLD  = ST_USER_HOLD,
      LINK_WAIT  = ST_LINK_WAIT,
      DONE       = ST_DONE,
      ERROR      = ST_ERROR
   } state_t;
endpackage

// File: rtl/pcie_rst_seq_timer.sv
// pcie_rst_seq_timer: saturating delay counter; term flags the last cycle of a lim-cycle window.
module pcie_rst_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] lim,
   output logic         term
);
   localparam logic [W-1:0] ONE = W'(1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && cnt != '1) cnt <= cnt + ONE;
   // a zero-length window still occupies one cycle
   assign term = (lim == '0) || (cnt == lim - ONE);
endmodule

// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: PCIe PERST#/user-reset sequencer with registered outputs.
// Define SEQ_LINK_TIMEOUT_EN to send a stalled LINK_WAIT to ERROR after LINK_TIMEOUT cycles.
module pcie_rst_seq
   import pcie_rst_seq_pkg::*;
#(
   parameter int PERST_CYCLES = 100,
   parameter int USER_DELAY   = 16,
   parameter int LINK_TIMEOUT = 4096,
   parameter int CNT_W        = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       clk_locked,
   input  logic       start,
   input  logic       link_up,
   output logic       perst_n,
   output logic       user_rst,
   output logic       seq_done,
   output logic       seq_err,
   output logic [2:0] state_o
);
   localparam longint MAXV = (64'sd1 <<< CNT_W) - 64'sd1;
   if (PERST_CYCLES > MAXV || USER_DELAY > MAXV || LINK_TIMEOUT > MAXV) begin : g_range
      $error("pcie_rst_seq: delay parameter exceeds counter range");
   end
   state_t state, nxt;
   logic cnting, term;
   logic [CNT_W-1:0] lim;
   assign cnting = state inside {PERST_HOLD, USER_HOLD, LINK_WAIT};
   assign lim = state == PERST_HOLD ? CNT_W'(PERST_CYCLES) :
                state == USER_HOLD  ? CNT_W'(USER_DELAY) : CNT_W'(LINK_TIMEOUT);
   // counter restarts from zero whenever a timed state is entered
   pcie_rst_seq_timer #(.W(CNT_W)) u_timer (
      .clk(sys_clk), .rst(sys_rst), .clr(!cnting || term), .en(cnting), .lim(lim), .term(term)
   );
   always_comb begin
      nxt = state;
      case (state)
         WAIT_LOCK:  if (clk_locked) nxt = PERST_HOLD;
         PERST_HOLD: if (term) nxt = USER_HOLD;
         USER_HOLD:  if (term) nxt = LINK_WAIT;
`ifdef SEQ_LINK_TIMEOUT_EN
         LINK_WAIT:  nxt = link_up ? DONE : term ? ERROR : LINK_WAIT;
`else
         LINK_WAIT:  if (link_up) nxt = DONE;
`endif
         DONE:       if (!link_up) nxt = LINK_WAIT;
         default:    nxt = state;
      endcase
      if (!clk_locked && !(state inside {IDLE, ERROR})) nxt = WAIT_LOCK;
      if (start) nxt = WAIT_LOCK;
   end
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state    <= IDLE;
         perst_n  <= 1'b0;
         user_rst <= 1'b1;
         seq_done <= 1'b0;
`ifdef SEQ_LINK_TIMEOUT_EN
         seq_err  <= 1'b0;
`endif
      end else begin
         state    <= nxt;
         perst_n  <= nxt inside {USER_HOLD, LINK_WAIT, DONE};
         user_rst <= !(nxt inside {LINK_WAIT, DONE});
         seq_done <= nxt == DONE;
`ifdef SEQ_LINK_TIMEOUT_EN
         seq_err  <= nxt == ERROR;
`endif
      end
`ifndef SEQ_LINK_TIMEOUT_EN
   assign seq_err = 1'b0;
`endif
   assign state_o = state;
endmodule

// File: doc/pcie_rst_seq.md
PCIE_RST_SEQ -- requirements
Module: pcie_rst_seq

Interface
REQ-001 SHALL have parameter PERST_CYCLES, default 100: sys_clk cycles perst_n held low after lock.
REQ-002 SHALL have parameter USER_DELAY, default 16: cycles from perst_n release to user_rst deassert.
REQ-003 SHALL have parameter LINK_TIMEOUT, default 4096: max cycles waiting for link_up.
REQ-004 SHALL have parameter CNT_W, default 16: width of the shared delay counter.
REQ-005 sys_clk  input  1  single clock for all logic.
REQ-006 sys_rst  input  1  asynchronous, active-high reset.
REQ-007 clk_locked  input  1  reference-clock/MMCM lock indication, synchronous to sys_clk.
REQ-008 start  input  1  one-cycle pulse requesting a (re)sequence.
REQ-009 link_up  input  1  endpoint link-up status.
REQ-010 perst_n  output  1  PCIe fundamental reset to the endpoint, active-low.
REQ-011 user_rst  output  1  user-logic reset, active-high.
REQ-012 seq_done  output  1  high while in DONE.
REQ-013 seq_err  output  1  high while in ERROR.
REQ-014 state_o  output  3  current state encoding.

Function
REQ-015 States SHALL be IDLE, WAIT_LOCK, PERST_HOLD, USER_HOLD, LINK_WAIT, DONE, ERROR.
REQ-016 IDLE: perst_n=0, user_rst=1; start -> WAIT_LOCK.
REQ-017 WAIT_LOCK: clk_locked=1 -> PERST_HOLD, counter cleared on entry.
REQ-018 PERST_HOLD: perst_n=0 for exactly PERST_CYCLES cycles; perst_n rises on the cycle after the count reaches PERST_CYCLES-1; -> USER_HOLD.
REQ-019 USER_HOLD: perst_n=1, user_rst=1 for exactly USER_DELAY cycles; -> LINK_WAIT with user_rst=0.
REQ-020 LINK_WAIT: link_up=1 -> DONE; outputs perst_n=1, user_rst=0.
REQ-021 DONE: seq_done=1; link_up falling -> LINK_WAIT (perst_n stays 1).
REQ-022 clk_locked=0 in any state except IDLE/ERROR SHALL force WAIT_LOCK next cycle with perst_n=0, user_rst=1 registered.
REQ-023 start in any non-IDLE state SHALL restart at WAIT_LOCK; start and lock loss in same cycle -> WAIT_LOCK.
REQ-024 ERROR: perst_n=0, user_rst=1, seq_err=1; exit only on start -> WAIT_LOCK.
REQ-025 Counter SHALL saturate at 2^CNT_W-1, never wrap; parameters exceeding 2^CNT_W-1 are an elaboration error.
REQ-026 PERST_CYCLES=0 or USER_DELAY=0 SHALL skip that state in one cycle.
REQ-027 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-028 sys_rst high SHALL asynchronously force IDLE, perst_n=0, user_rst=1, seq_done=0, seq_err=0, counter=0.
REQ-029 Reset deassertion SHALL be synchronous-release; sequencing starts only on a later start pulse.

Configuration
REQ-030 With SEQ_LINK_TIMEOUT_EN defined, LINK_WAIT exceeding LINK_TIMEOUT cycles SHALL go to ERROR.
REQ-031 Without SEQ_LINK_TIMEOUT_EN, LINK_WAIT SHALL wait indefinitely; ERROR unreachable, seq_err tied 0.

Structure
REQ-032 Package pcie_rst_seq_pkg SHALL hold the state enum and its 3-bit encoding constants.
REQ-033 Sub-module pcie_rst_seq_timer (load/clear, enable, saturating count, terminal flag) SHALL implement the delay counter.

Verification
REQ-034 Reset, start, clk_locked=1 at cycle 5 -> perst_n rises exactly 100 cycles after PERST_HOLD entry; user_rst falls 16 cycles later.
REQ-035 link_up asserted 50 cycles into LINK_WAIT -> seq_done=1 next cycle; link_up dropped -> seq_done=0, state LINK_WAIT.
REQ-036 clk_locked dropped at PERST_HOLD cycle 40 -> WAIT_LOCK, perst_n stays 0; relock -> full 100-cycle hold restarts.
REQ-037 SEQ_LINK_TIMEOUT_EN defined, link_up never asserted -> seq_err=1 after 4096 LINK_WAIT cycles, perst_n=0; start -> WAIT_LOCK.
REQ-038 sys_rst pulsed mid-USER_HOLD -> perst_n=0, user_rst=1 immediately (asynchronous), state IDLE.
REQ-039 PERST_CYCLES=0, USER_DELAY=0 -> perst_n=1 within 2 cycles of lock, user_rst=0 one cycle later.
